// File: rtl/mmio_axil_bridge.sv
// mmio_axil_bridge: buffers core MMIO load/store requests in a small FIFO and
// issues them one at a time as AXI4-Lite master transactions, returning one
// in-order response per request.
// Optional feature: define MMIO_TIMEOUT_EN to enable the response watchdog
// (TIMEOUT cycles); without it the bridge waits indefinitely for the slave.

module mmio_axil_bridge #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RSTn,
    // Core request side
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [63:0] req_data,
    input  logic [7:0]  req_wstrb,
    // Core response side
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic        rsp_err,
    // AXI4-Lite write address
    output logic [31:0] MMIO_AWADDR,
    output logic        MMIO_AWVALID,
    input  logic        MMIO_AWREADY,
    // AXI4-Lite write data
    output logic [63:0] MMIO_WDATA,
    output logic [7:0]  MMIO_WSTRB,
    output logic        MMIO_WVALID,
    input  logic        MMIO_WREADY,
    // AXI4-Lite write response
    input  logic [1:0]  MMIO_BRESP,
    input  logic        MMIO_BVALID,
    output logic        MMIO_BREADY,
    // AXI4-Lite read address
    output logic [31:0] MMIO_ARADDR,
    output logic        MMIO_ARVALID,
    input  logic        MMIO_ARREADY,
    // AXI4-Lite read data
    input  logic [63:0] MMIO_RDATA,
    input  logic [1:0]  MMIO_RRESP,
    input  logic        MMIO_RVALID,
    output logic        MMIO_RREADY
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
    } req_t;

    typedef enum logic [2:0] {
        StIdle,
        StWaddr,
        StWresp,
        StRaddr,
        StRdata,
        StRsp
    } state_e;

    req_t          fifo_q [DEPTH];
    req_t          head;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic          full, empty, push, pop;

    state_e        state_q, state_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic [63:0]   rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;
    logic          tmo_hit;

    // Full/empty come from registered pointers only, so a pop never frees a
    // slot for a push in the same cycle.
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                       (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign req_ready = ~full;
    assign push      = req_valid & ~full;
    assign pop       = (state_q == StRsp) & rsp_ready;
    assign head      = fifo_q[rd_ptr_q[AW-1:0]];

    // Payload comes straight from the head entry, which cannot change until
    // the response is consumed, so it is stable while any valid is high.
    assign MMIO_AWADDR = head.addr;
    assign MMIO_ARADDR = head.addr;
    assign MMIO_WDATA  = head.data;
    assign MMIO_WSTRB  = head.strb;

    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

    // FIFO storage write
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_q[wr_ptr_q[AW-1:0]] <= {req_wen, req_addr, req_data, req_wstrb};
        end
    end

    // FIFO pointers
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

`ifdef MMIO_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt_q;
    logic          busy;

    assign busy    = (state_q == StWaddr) || (state_q == StWresp) ||
                     (state_q == StRaddr) || (state_q == StRdata);
    // Fires on the TIMEOUT-th cycle spent with an AXI transaction open
    assign tmo_hit = busy && (tmo_cnt_q == TW'(TIMEOUT - 1));

    // Watchdog counter: zero outside an open transaction, counts inside one
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            tmo_cnt_q <= '0;
        end else if (busy) begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
        end else begin
            tmo_cnt_q <= '0;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign tmo_hit        = 1'b0;
`endif

    // FSM and captured response registers
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= StIdle;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Next-state and AXI/response handshake outputs
    always_comb begin
        state_d      = state_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        MMIO_AWVALID = 1'b0;
        MMIO_WVALID  = 1'b0;
        MMIO_BREADY  = 1'b0;
        MMIO_ARVALID = 1'b0;
        MMIO_RREADY  = 1'b0;
        rsp_valid    = 1'b0;

        case (state_q)
            StIdle: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (!empty) begin
                    state_d = head.wen ? StWaddr : StRaddr;
                end
            end
            StWaddr: begin
                // Both valids rise together; each drops after its own handshake
                MMIO_AWVALID = ~aw_done_q;
                MMIO_WVALID  = ~w_done_q;
                if (!aw_done_q && MMIO_AWREADY) aw_done_d = 1'b1;
                if (!w_done_q && MMIO_WREADY)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) begin
                    state_d = StWresp;
                end else if (tmo_hit) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = StRsp;
                end
            end
            StWresp: begin
                MMIO_BREADY = 1'b1;
                if (MMIO_BVALID) begin
                    rsp_data_d = '0;
                    rsp_err_d  = |MMIO_BRESP;
                    state_d    = StRsp;
                end else if (tmo_hit) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = StRsp;
                end
            end
            StRaddr: begin
                MMIO_ARVALID = 1'b1;
                if (MMIO_ARREADY) begin
                    state_d = StRdata;
                end else if (tmo_hit) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = StRsp;
                end
            end
            StRdata: begin
                MMIO_RREADY = 1'b1;
                if (MMIO_RVALID) begin
                    rsp_data_d = MMIO_RDATA;
                    rsp_err_d  = |MMIO_RRESP;
                    state_d    = StRsp;
                end else if (tmo_hit) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = StRsp;
                end
            end
            StRsp: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule
